// File: rtl/rgb2hsv_seq.sv
// Sequential integer RGB-to-HSV converter: one-cycle decode, then two restoring
// dividers (hue fraction and saturation) sharing a CW-cycle iteration window.
module rgb2hsv_seq #(
  parameter int CW       = 8,
  parameter int SEG_BITS = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_r,
  input  logic [CW-1:0]       in_g,
  input  logic [CW-1:0]       in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SEG_BITS+2:0] out_h,
  output logic [CW-1:0]       out_s,
  output logic [CW-1:0]       out_v,
  output logic                out_gray,
  output logic                busy
);

  localparam int HW    = SEG_BITS + 1;
  localparam int CNT_W = $clog2(CW + 1);
  localparam logic [CNT_W-1:0] HUE_LAST = CNT_W'(SEG_BITS);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEG_BITS+2:0]  out_h_q, out_h_d;
  logic [CW-1:0]        out_s_q, out_s_d, out_v_q, out_v_d;
  logic                 out_gray_q, out_gray_d;

  logic [CW-1:0]        r_q, r_d, g_q, g_d, b_q, b_d;
  logic [CW-1:0]        max_q, max_d, d_q, d_d;
  logic [2:0]           sector_q, sector_d;
  logic                 gray_q, gray_d;
  logic [CW-1:0]        remh_q, remh_d, rems_q, rems_d;
  logic [HW-1:0]        shh_q, shh_d, qh_q, qh_d;
  logic [CW-1:0]        shs_q, shs_d, qs_q, qs_d;

  logic [CW-1:0]        mx, mn, dd, num;
  logic [2:0]           sec;
  logic [2*CW-1:0]      sat_num;
  logic [CW:0]          stph, stps;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  // Result is {quotient_bit, new_remainder}.
  function automatic logic [CW:0] div_step(input logic [CW-1:0] rem,
                                           input logic bit_in,
                                           input logic [CW-1:0] dvs);
    logic [CW:0] p;
    logic [CW:0] diff;
    p    = {rem, bit_in};
    diff = p - {1'b0, dvs};
    if (p >= {1'b0, dvs}) div_step = {1'b1, diff[CW-1:0]};
    else                  div_step = {1'b0, p[CW-1:0]};
  endfunction

  // Decode: max with R>G>B tie priority, hue sector and its numerator.
  always_comb begin
    mx  = r_q;
    mn  = b_q;
    num = '0;
    sec = 3'd0;
    if (r_q >= g_q && r_q >= b_q) begin
      mx = r_q;
      if (g_q >= b_q) begin sec = 3'd0; num = g_q - b_q; mn = b_q; end
      else            begin sec = 3'd5; num = r_q - b_q; mn = g_q; end
    end else if (g_q >= b_q) begin
      mx = g_q;
      if (r_q > b_q)  begin sec = 3'd1; num = g_q - r_q; mn = b_q; end
      else            begin sec = 3'd2; num = b_q - r_q; mn = r_q; end
    end else begin
      mx = b_q;
      if (g_q > r_q)  begin sec = 3'd3; num = b_q - g_q; mn = r_q; end
      else            begin sec = 3'd4; num = r_q - g_q; mn = g_q; end
    end
    dd      = mx - mn;
    // d*(2^CW-1) = d*2^CW - d; its upper half (d-1) is always below max.
    sat_num = {dd, {CW{1'b0}}} - {{CW{1'b0}}, dd};
  end

  assign stph = div_step(remh_q, shh_q[HW-1], d_q);
  assign stps = div_step(rems_q, shs_q[CW-1], max_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_h_d    = out_h_q;
    out_s_d    = out_s_q;
    out_v_d    = out_v_q;
    out_gray_d = out_gray_q;
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;
    max_d      = max_q;
    d_d        = d_q;
    sector_d   = sector_q;
    gray_d     = gray_q;
    remh_d     = remh_q;
    shh_d      = shh_q;
    qh_d       = qh_q;
    rems_d     = rems_q;
    shs_d      = shs_q;
    qs_d       = qs_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d     = in_r;
          g_d     = in_g;
          b_d     = in_b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        max_d    = mx;
        d_d      = dd;
        sector_d = sec;
        gray_d   = (dd == '0);
        // Hue dividend is num*2^SEG_BITS; num <= d keeps the top partial below 2d.
        remh_d   = {1'b0, num[CW-1:1]};
        shh_d    = {num[0], {SEG_BITS{1'b0}}};
        qh_d     = '0;
        rems_d   = sat_num[2*CW-1:CW];
        shs_d    = sat_num[CW-1:0];
        qs_d     = '0;
        cnt_d    = '0;
        state_d  = DIV;
      end
      DIV: begin
        if (cnt_q <= HUE_LAST) begin
          remh_d = stph[CW-1:0];
          shh_d  = shh_q << 1;
          qh_d   = {qh_q[HW-2:0], stph[CW]};
        end
        rems_d = stps[CW-1:0];
        shs_d  = shs_q << 1;
        qs_d   = {qs_q[CW-2:0], stps[CW]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          out_v_d    = max_q;
          out_gray_d = gray_q;
          out_h_d    = gray_q ? '0 : ({sector_q, {SEG_BITS{1'b0}}} + {2'b00, qh_d});
          out_s_d    = gray_q ? '0 : qs_d;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_h_q    <= '0;
      out_s_q    <= '0;
      out_v_q    <= '0;
      out_gray_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_h_q    <= out_h_d;
      out_s_q    <= out_s_d;
      out_v_q    <= out_v_d;
      out_gray_q <= out_gray_d;
    end
  end

  always_ff @(posedge clk) begin
    r_q      <= r_d;
    g_q      <= g_d;
    b_q      <= b_d;
    max_q    <= max_d;
    d_q      <= d_d;
    sector_q <= sector_d;
    gray_q   <= gray_d;
    remh_q   <= remh_d;
    shh_q    <= shh_d;
    qh_q     <= qh_d;
    rems_q   <= rems_d;
    shs_q    <= shs_d;
    qs_q     <= qs_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_h     = out_h_q;
  assign out_s     = out_s_q;
  assign out_v     = out_v_q;
  assign out_gray  = out_gray_q;

endmodule

// File: tb/tb_rgb2hsv_seq.sv
// Scoreboard bench for rgb2hsv_seq: driver pushes model results on accept,
// monitor pops and compares whenever a result is handed off.
module tb_rgb2hsv_seq;
  localparam int CW = 8;
  localparam int SB = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_r, in_g, in_b;
  logic          out_valid;
  logic          out_ready;
  logic [SB+2:0] out_h;
  logic [CW-1:0] out_s, out_v;
  logic          out_gray;
  logic          busy;

  rgb2hsv_seq #(.CW(CW), .SEG_BITS(SB)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_h(out_h), .out_s(out_s), .out_v(out_v), .out_gray(out_gray),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int s;
    int v;
    int g;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mode = 0;   // 0: out_ready=1, 1: out_ready=0, 2: random

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: standard hexcone HSV in integer counts, sector chosen from the ordering of r,g,b.
  function automatic exp_t model(input int r, input int g, input int b);
    exp_t e;
    int mx, mn, d, sec, num;
    mx = (r >= g && r >= b) ? r : ((g >= b) ? g : b);
    mn = (r <= g && r <= b) ? r : ((g <= b) ? g : b);
    d  = mx - mn;
    e.v = mx;
    e.acc = 0;
    sec = 0;
    num = 0;
    if (d == 0) begin
      e.h = 0; e.s = 0; e.g = 1;
      return e;
    end
    if (r >= g && r >= b) begin
      if (g >= b) begin sec = 0; num = g - b; end
      else        begin sec = 5; num = r - b; end
    end else if (g >= b) begin
      if (r > b)  begin sec = 1; num = g - r; end
      else        begin sec = 2; num = b - r; end
    end else begin
      if (g > r)  begin sec = 3; num = b - g; end
      else        begin sec = 4; num = r - g; end
    end
    e.h = sec * (1 << SB) + (num * (1 << SB)) / d;
    e.s = (d * ((1 << CW) - 1)) / mx;
    e.g = 0;
    return e;
  endfunction

  task automatic send(input int r, input int g, input int b);
    exp_t e;
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_r = CW'(r); in_g = CW'(g); in_b = CW'(b);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept", int'(in_ready), 1);
    if (in_ready) begin
      e = model(r, g, b);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  // Monitor
  initial begin
    logic pv, held;
    int hh, hs, hv, hg;
    exp_t e;
    pv = 1'b0; held = 1'b0;
    hh = 0; hs = 0; hv = 0; hg = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pv = 1'b0; held = 1'b0;
        continue;
      end
      if (out_valid && held) begin
        chk("hold_h", int'(out_h), hh);
        chk("hold_s", int'(out_s), hs);
        chk("hold_v", int'(out_v), hv);
        chk("hold_gray", int'(out_gray), hg);
      end
      // The accepting edge counts as the first of the CW+2 edges.
      if (out_valid && !pv) begin
        chk("output_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) chk("latency", cyc - sb[0].acc, CW + 1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("h", int'(out_h), e.h);
          chk("s", int'(out_s), e.s);
          chk("v", int'(out_v), e.v);
          chk("gray", int'(out_gray), e.g);
        end
        held = 1'b0;
      end else if (out_valid) begin
        held = 1'b1;
        hh = int'(out_h); hs = int'(out_s); hv = int'(out_v); hg = int'(out_gray);
      end else begin
        held = 1'b0;
      end
      pv = out_valid;
    end
  end

  int dr[10] = '{255,   0,   0, 255,   0, 255, 200,  50, 128, 0};
  int dg[10] = '{  0, 255,   0, 255, 255,   0, 100, 100, 128, 0};
  int db[10] = '{  0,   0, 255,   0, 255, 255,  50, 200, 128, 0};

  initial begin
    int r, g, b;
    resetn = 1'b0; in_valid = 1'b0;
    in_r = '0; in_g = '0; in_b = '0;
    mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_h", int'(out_h), 0);
    chk("rst_out_s", int'(out_s), 0);
    chk("rst_out_v", int'(out_v), 0);
    chk("rst_out_gray", int'(out_gray), 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 10; i++) begin
      send(dr[i], dg[i], db[i]);
      drain();
    end

    // Backpressure with a busy input side.
    mode = 1;
    send(200, 100, 50);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("bp_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_r = CW'($urandom); in_g = CW'($urandom); in_b = CW'($urandom);
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
    end
    in_valid = 1'b0;
    mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_out_valid", int'(out_valid), 0);
    drain();

    // Asynchronous reset in the third DIV cycle.
    send(77, 33, 99);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", int'(busy), 1);
    resetn = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    send(10, 20, 30);
    drain();

    // Randomised traffic with random backpressure.
    mode = 2;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 255);
      g = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      case ($urandom_range(0, 7))
        0: begin g = r; b = r; end
        1: g = r;
        2: b = g;
        default: ;
      endcase
      send(r, g, b);
    end
    drain();
    mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
